// File: rtl/mealy_ctrl_pkg.sv
// Shared definitions for the programmable Mealy controller: entry layout helpers,
// the fixed initial state and the run/idle mode encoding.
package mealy_ctrl_pkg;

    // Table entry layout, MSB to LSB: {end, next_state, out}
    localparam int unsigned END_W   = 1;
    localparam int unsigned OUT_LSB = 0;

    // Fixed initial state every algorithm starts from
    localparam int unsigned S0 = 0;

    typedef enum logic {
        CTRL_IDLE = 1'b0,
        CTRL_RUN  = 1'b1
    } ctrl_e;

    function automatic int unsigned ns_lsb(input int unsigned n_out);
        return OUT_LSB + n_out;
    endfunction

    function automatic int unsigned end_pos(input int unsigned sw, input int unsigned n_out);
        return ns_lsb(n_out) + sw;
    endfunction

    function automatic int unsigned entry_width(input int unsigned sw, input int unsigned n_out);
        return END_W + sw + n_out;
    endfunction

endpackage

// File: rtl/mealy_ctrl_table.sv
// Program store for the Mealy controller: one synchronous write port and one
// asynchronous read port so the looked-up entry drives outputs in the same cycle.
module mealy_ctrl_table #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];

    // NOTE: the array has no reset; the loaded program must survive a controller reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mealy_ctrl_prog.sv
// Programmable Mealy-automaton controller: table-driven transitions and micro-op
// strobes, start/done handshake, run-enable hold, gated table writes.
// Optional illegal-state detection is built when MEALY_CTRL_ILLEGAL_CHK_EN is defined.
module mealy_ctrl_prog
    import mealy_ctrl_pkg::*;
#(
    parameter int unsigned N_IN     = 2,
    parameter int unsigned N_OUT    = 9,
    parameter int unsigned SW       = 4,
    parameter int unsigned N_STATES = 10
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic                  en,
    input  logic [N_IN-1:0]       x,
    input  logic                  cfg_we,
    input  logic [SW+N_IN-1:0]    cfg_addr,
    input  logic [SW+N_OUT:0]     cfg_data,
    output logic [N_OUT-1:0]      t,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  err
);

    localparam int unsigned AW      = SW + N_IN;
    localparam int unsigned DW      = entry_width(SW, N_OUT);
    localparam int unsigned END_POS = end_pos(SW, N_OUT);
    localparam int unsigned NS_LSB  = ns_lsb(N_OUT);

    ctrl_e             mode_q, mode_d;
    logic [SW-1:0]     state_q, state_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              err_q, err_d;

    logic [DW-1:0]     entry;
    logic              entry_end;
    logic [SW-1:0]     entry_ns;
    logic [N_OUT-1:0]  entry_out;
    logic              running;
    logic              illegal;
    logic              tbl_we;

    assign running = (mode_q == CTRL_RUN);
    assign tbl_we  = cfg_we && !running;

    mealy_ctrl_table #(
        .AW (AW),
        .DW (DW)
    ) u_table (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr ({state_q, x}),
        .rdata (entry)
    );

    assign entry_end = entry[END_POS];
    assign entry_ns  = entry[NS_LSB +: SW];
    assign entry_out = entry[OUT_LSB +: N_OUT];

`ifdef MEALY_CTRL_ILLEGAL_CHK_EN
    assign illegal = running && (32'(state_q) >= N_STATES);
`else
    assign illegal = 1'b0;
`endif

    // Mealy outputs: straight from the looked-up entry, masked when not actively running
    assign t = (running && en && !illegal) ? entry_out : '0;

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        mode_d    = mode_q;
        state_d   = state_q;
        done_d    = 1'b0;
        cfg_err_d = cfg_we && running;
        err_d     = err_q;

        case (mode_q)
            CTRL_IDLE: begin
                state_d = SW'(S0);
                if (start) begin
                    mode_d = CTRL_RUN;
                end
            end
            CTRL_RUN: begin
                if (illegal) begin
                    state_d = SW'(S0);
                    mode_d  = CTRL_IDLE;
                    err_d   = 1'b1;
                end else if (en) begin
                    if (entry_end) begin
                        state_d = SW'(S0);
                        mode_d  = CTRL_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = entry_ns;
                    end
                end
            end
            default: begin
                state_d = SW'(S0);
                mode_d  = CTRL_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments only, so all flops update together at the edge.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mode_q    <= CTRL_IDLE;
            state_q   <= SW'(S0);
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            state_q   <= state_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            err_q     <= err_d;
        end
    end

    assign busy    = running;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;
    assign err     = err_q;

endmodule

// File: doc/mealy_ctrl_prog.md
# mealy_ctrl_prog

Programmable Mealy-automaton controller: a parametrised successor to our hard-wired flowchart controllers. The state-transition and micro-operation logic lives in a writable table rather than fixed gate equations. A new control algorithm is loaded through a configuration port instead of resynthesising. It sits between the datapath's condition flags (inputs `x`) and the datapath's micro-operation strobes (outputs `t`). It adds a start/done handshake, a run-enable hold and optional illegal-state detection.

## Interface
- `N_IN`, 2: number of condition inputs.
- `N_OUT`, 9: number of micro-operation outputs.
- `SW`, 4: state register width.
- `N_STATES`, 10: number of legal states (≤ 2^SW); states `N_STATES`..2^SW−1 are illegal.
- `clk` input 1: single clock, rising edge.
- `res` input 1: reset, asynchronous, active-low.
- `start` input 1: start request, sampled at `clk` rising edge.
- `en` input 1: run enable; 0 freezes state and forces `t` to 0.
- `x` input N_IN: condition inputs.
- `cfg_we` input 1: table write strobe.
- `cfg_addr` input SW+N_IN: table address {state, x}.
- `cfg_data` input SW+N_OUT+1: entry {end, next_state, out}.
- `t` output N_OUT: micro-operations (Mealy, combinational from state and `x`).
- `busy` output 1: controller running.
- `done` output 1: one-cycle pulse at algorithm end.
- `cfg_err` output 1: one-cycle pulse on a rejected table write.
- `err` output 1: sticky illegal-state flag.

## Operation
- Table: 2^(SW+N_IN) entries; address {state, x}. Entry fields: `end` (MSB), `next_state` (SW bits), `out` (N_OUT bits, LSBs). Contents are not cleared by reset.
- Idle (`busy`=0): state register = 0; `t`=0.
  - `start`=1 at an edge: `busy`←1, state stays 0 (S0 is the fixed initial state).
  - `start` while `busy`=1: ignored.
- Run (`busy`=1, `en`=1): `t` = table[{state,x}].out. At each edge, state ← that entry's `next_state`.
  - If the entry's `end`=1: state←0, `busy`←0, `done`←1 for the next cycle.
- Run with `en`=0: state and `busy` hold; `t`=0.
- Writes:
  - `cfg_we` is accepted only while `busy`=0; the entry is written at the edge.
  - `cfg_we` while `busy`=1: write dropped; `cfg_err`=1 for the next cycle.
- Same-edge `start` and `cfg_we` while idle: both are accepted; the first lookup uses the new contents.
- Reset (`res`=0, any time, including mid-run): state=0, `busy`=0, `done`=0, `cfg_err`=0, `err`=0, hence `t`=0. Table contents are preserved.

## Timing
- Outputs `t` are combinational: valid in the same cycle as state/`x` changes, with no register stage.
- `start` at edge k: the first `t` is in cycle k..k+1 and the first transition is at edge k+1.
- An end entry taken at edge n: `busy`=0 and `done`=1 during cycle n..n+1; `done`=0 after edge n+1.
- An algorithm of L transitions (including the end one) keeps `busy` high for L cycles when `en` is held at 1.
- `cfg_err` rises one edge after the rejected write and is high for one cycle.
- `err` is set at the edge it is detected and cleared only by `res`.

## Configuration
- `MEALY_CTRL_ILLEGAL_CHK_EN` defined:
  - If `busy`=1 and state ≥ `N_STATES`, then `t`=0 in that cycle.
  - At the next edge: state←0, `busy`←0, `err`←1. No `done` pulse is generated.
- Undefined: no check. Illegal states follow the table like any other state, and `err` is tied to 0.

## Structure
- Package `mealy_ctrl_pkg` holds:
  - entry field widths;
  - offset functions for `end`/`next_state`/`out` given SW and N_OUT;
  - the S0 constant.
- Sub-module `mealy_ctrl_table`: RAM with one synchronous write port and one asynchronous read port, parametrised by address and data width.
- Top level contains the state register, the busy/done/err logic and write gating.

## Test plan
- Reset mid-run:
  - Program S0 to loop to itself with out=9'h001, then `start`.
  - Drive `res`=0 mid-cycle → `busy`, `t`, state drop to 0 immediately.
  - After `res`=1 with no new `start`, the table still holds 9'h001 and `t` stays 0.
- Three-state run with N_IN=2:
  - Table: S0,x=1→S1 out 9'h002; S1,x=1→S2 out 9'h100; S2,x=1 end out 9'h010.
  - With `x`=1 and `start` → `t` is 002, 100, 010 on consecutive cycles; `busy` is high for 3 cycles; `done` is one pulse after the 3rd edge.
- Input branching: S0,x=0→S3 out 9'h004 vs S0,x=1→S1 out 9'h002. Toggling `x` in cycle 1 switches `t` combinationally between 004 and 002 within the cycle, and the next state follows `x` at the edge.
- Hold: deassert `en` for 2 cycles in the middle of the three-state run → `t`=0 and the state is frozen. The run resumes and `done` arrives 2 cycles late.
- Write rejection:
  - `cfg_we` while `busy`=1 → `cfg_err` pulses once and the entry is unchanged (read back by a later run).
  - `start` while busy → no effect.
- Illegal state: set S1 next_state to 12 (N_STATES=10).
  - With the macro defined → `err`=1, `busy`=0 and no `done`.
  - Without the macro → the run continues through entry {12,x}.
